uart_rx_deserializer: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_deserializer.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default oversampling and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line (idles high) with a falling-edge pulse on the synchronised value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic [1:0] sync_reg;
  logic       rx_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= sync_reg[1];
    end
  end

  assign rx_s    = sync_reg[1];
  assign rx_fall = rx_prev_reg & ~sync_reg[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// 16x-oversampled UART receiver: one parallel word plus error flags per frame.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote instead of a single sample.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  break_detect,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic                  rx_s;
  logic                  rx_fall;
  logic                  bit_val;
  rx_state_t             state_reg;
  logic [TW-1:0]         tick_cnt_reg;
  logic [BW-1:0]         bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_reg;
  logic                  par_odd_reg;
  logic                  par_bit_reg;
  logic [DATA_WIDTH-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic                  frame_error_reg;
  logic                  parity_error_reg;
  logic                  break_detect_reg;
  logic                  busy_reg;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The vote window closes on the decision tick itself, so decision timing matches the single-sample build.
  logic [1:0] hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= 2'b11;
    end else if (baud_tick) begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign bit_val = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      tick_cnt_reg     <= '0;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      par_en_reg       <= 1'b0;
      par_odd_reg      <= 1'b0;
      par_bit_reg      <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      frame_error_reg  <= 1'b0;
      parity_error_reg <= 1'b0;
      break_detect_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_fall) begin
            state_reg    <= START;
            tick_cnt_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt_reg == HALF_LAST) begin
              tick_cnt_reg <= '0;
              if (!bit_val) begin
                state_reg   <= DATA;
                bit_cnt_reg <= '0;
                par_en_reg  <= parity_en;
                par_odd_reg <= parity_odd;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg <= '0;
              shift_reg    <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg <= par_en_reg ? PARITY : STOP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg <= '0;
              par_bit_reg  <= bit_val;
              state_reg    <= STOP;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg     <= '0;
              rx_valid_reg     <= 1'b1;
              rx_data_reg      <= shift_reg;
              frame_error_reg  <= ~bit_val;
              parity_error_reg <= par_en_reg &
                                  (par_bit_reg != parity_calc(8'(shift_reg), par_odd_reg));
              // A break needs the parity slot low too, so a frame with parity bit 1 is not a break.
              break_detect_reg <= (shift_reg == '0) & ~bit_val & ~(par_en_reg & par_bit_reg);
              state_reg        <= IDLE;
              busy_reg         <= 1'b0;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign frame_error  = frame_error_reg;
  assign parity_error = parity_error_reg;
  assign break_detect = break_detect_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: table-driven frames plus hand-written corner sequences, checked through an expected-frame queue.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       break_detect;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       flip_par;
    logic       stop_bit;
    logic       cfg_flip;
    logic       fe;
    logic       pe;
    logic       bd;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       bd;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stop_start_cyc = 0;

  uart_rx_deserializer #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .break_detect (break_detect),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // baud_tick: one clk in every four.
  initial begin
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete, cycle=%0d required <80000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  // Scoreboard side: every rx_valid strobe pops one expected frame.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks = n_checks + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_rx_valid: got strobe with rx_data=%02h, required none", rx_data);
        end else begin
          e = exp_q.pop_front();
          d = cyc - stop_start_cyc;
          check("rx_data", rx_data, e.data);
          check("frame_error", {7'd0, frame_error}, {7'd0, e.fe});
          check("parity_error", {7'd0, parity_error}, {7'd0, e.pe});
          check("break_detect", {7'd0, break_detect}, {7'd0, e.bd});
          n_checks = n_checks + 1;
          if (d < 31 || d > 37) begin
            n_fail = n_fail + 1;
            $display("FAIL latency: got %0d clk after stop-bit start, required 31..37", d);
          end
          $display("frame rx_data=%02h fe=%0b pe=%0b bd=%0b latency=%0d", rx_data, frame_error,
                   parity_error, break_detect, d);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pen, input logic podd,
                            input logic flip_par, input logic stop_bit, input logic cfg_flip);
    parity_en  = pen;
    parity_odd = podd;
    drive_bit(1'b0);
    if (cfg_flip) begin
      parity_en  = ~pen;
      parity_odd = ~podd;
    end
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (pen) drive_bit((^data) ^ podd ^ flip_par);
    stop_start_cyc = cyc + 0;
    drive_bit(stop_bit);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_valid"}, {7'd0, rx_valid}, 8'd0);
    check({tag, "_rx_data"}, rx_data, 8'd0);
    check({tag, "_flags"}, {5'd0, frame_error, parity_error, break_detect}, 8'd0);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst        = 1'b1;
    rx         = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{vecs[i].data, vecs[i].fe, vecs[i].pe, vecs[i].bd});
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].flip_par, vecs[i].stop_bit,
                 vecs[i].cfg_flip);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check("busy_after_frame", {7'd0, busy}, 8'd0);
    end

    // Line held low for 12 bit times: one break frame, then nothing until the line rises
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    exp_q.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
    stop_start_cyc = cyc + 9 * BIT_CLKS;
    rx = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // False start: low for 3 ticks only
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    check("false_start_busy_early", {7'd0, busy}, 8'd1);
    repeat (16) @(negedge clk);
    check("false_start_busy_pre_mid", {7'd0, busy}, 8'd1);
    repeat (12) @(negedge clk);
    check("false_start_busy_after_mid", {7'd0, busy}, 8'd0);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Back-to-back frames, no idle gap
    for (int i = 1; i <= 3; i++) begin
      logic [7:0] b;
      b = 8'(i);
      exp_q.push_back('{b, 1'b0, 1'b0, 1'b0});
      send_frame(b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    drive_bit(1'b1);
    check("b2b_queue_drained", 8'(exp_q.size()), 8'd0);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("mid_frame_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(1'b1);
    exp_q.push_back('{8'h12, 1'b0, 1'b0, 1'b0});
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b1);

    check("final_queue_empty", 8'(exp_q.size()), 8'd0);
    check("final_busy", {7'd0, busy}, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
